game_flow_controller: RTL and testbench

Sequences a Road Fighter session: attract/idle, playing, crash recovery and game over. It gates the scroll and movement ticks, tracks lives and score, and clears the obstacle field on each new run. It sits between the collision detector and the motion blocks (player, obstacle manager, background scroll) in the top-level game. It also feeds score, lives and the crash-blink flag to the graphics path.

---
 rtl/game_flow_controller.sv | 160 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller: session sequencer for Road Fighter.
// Walks IDLE -> PLAY -> CRASH -> (PLAY | OVER) -> IDLE, gates the motion
// blocks through run_en, keeps lives/score and drives the crash blink.
// Every output is a flop so downstream blocks see glitch-free levels.
module game_flow_controller #(
    parameter int START_LIVES       = 3,
    parameter int CRASH_FRAMES      = 120,
    parameter int SCORE_STEP_FRAMES = 30,
    parameter int BLINK_FRAMES      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        colision,
    input  logic        frame_tick,
    output logic        run_en,
    output logic        clear_obs,
    output logic        crash_blink,
    output logic        game_over,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_CRASH = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  blink_cnt_q, blink_cnt_d;
    logic [1:0]  lives_q, lives_d;
    logic [15:0] score_q, score_d;
    logic        run_en_q, run_en_d;
    logic        clear_obs_q, clear_obs_d;
    logic        crash_blink_q, crash_blink_d;
    logic        game_over_q, game_over_d;
    logic        start_rise;

    assign start_rise = start & ~start_q;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d       = state_q;
        start_d       = start;
        step_cnt_d    = step_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        lives_d       = lives_q;
        score_d       = score_q;
        clear_obs_d   = 1'b0;
        crash_blink_d = crash_blink_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d     = S_PLAY;
                    lives_d     = 2'(START_LIVES);
                    score_d     = 16'd0;
                    clear_obs_d = 1'b1;
                    step_cnt_d  = 8'd0;
                end
            end
            S_PLAY: begin
                // A collision swallows a coincident frame tick.
                if (colision) begin
                    state_d       = S_CRASH;
                    lives_d       = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
                    frame_cnt_d   = 8'd0;
                    blink_cnt_d   = 4'd0;
                    crash_blink_d = 1'b1;
                end else if (frame_tick) begin
                    if (step_cnt_q == 8'(SCORE_STEP_FRAMES - 1)) begin
                        step_cnt_d = 8'd0;
                        if (score_q != 16'hFFFF)
                            score_d = score_q + 16'd1;
                    end else begin
                        step_cnt_d = step_cnt_q + 8'd1;
                    end
                end
            end
            S_CRASH: begin
                if (frame_tick) begin
                    if (blink_cnt_q == 4'(BLINK_FRAMES - 1)) begin
                        blink_cnt_d   = 4'd0;
                        crash_blink_d = ~crash_blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 4'd1;
                    end
                    if (frame_cnt_q == 8'(CRASH_FRAMES - 1)) begin
                        frame_cnt_d = 8'd0;
                        if (lives_q == 2'd0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d     = S_PLAY;
                            clear_obs_d = 1'b1;
                            step_cnt_d  = 8'd0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (start_rise)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Blink only ever shows while crashed.
        if (state_d != S_CRASH)
            crash_blink_d = 1'b0;
        run_en_d    = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            step_cnt_q    <= 8'd0;
            frame_cnt_q   <= 8'd0;
            blink_cnt_q   <= 4'd0;
            lives_q       <= 2'd0;
            score_q       <= 16'd0;
            run_en_q      <= 1'b0;
            clear_obs_q   <= 1'b0;
            crash_blink_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            step_cnt_q    <= step_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            run_en_q      <= run_en_d;
            clear_obs_q   <= clear_obs_d;
            crash_blink_q <= crash_blink_d;
            game_over_q   <= game_over_d;
        end
    end

    assign state       = state_q;
    assign run_en      = run_en_q;
    assign clear_obs   = clear_obs_q;
    assign crash_blink = crash_blink_q;
    assign game_over   = game_over_q;
    assign lives       = lives_q;
    assign score       = score_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: a session-level model checked every
// cycle, directed scenarios with literal expectations, a randomized phase,
// and a second instance (one tick per point) for score saturation.
module tb_game_flow_controller;

    localparam int LIVES0 = 3;
    localparam int CF     = 4;
    localparam int SSF    = 2;
    localparam int BF     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        reset, start, colision, frame_tick;
    logic        run_en, clear_obs, crash_blink, game_over;
    logic [1:0]  lives, state;
    logic [15:0] score;

    // Saturation instance signals
    logic        reset_b, start_b, colision_b, frame_tick_b;
    logic        run_en_b, clear_obs_b, crash_blink_b, game_over_b;
    logic [1:0]  lives_b, state_b;
    logic [15:0] score_b;

    game_flow_controller #(.START_LIVES(LIVES0), .CRASH_FRAMES(CF),
        .SCORE_STEP_FRAMES(SSF), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .start(start), .colision(colision),
        .frame_tick(frame_tick), .run_en(run_en), .clear_obs(clear_obs),
        .crash_blink(crash_blink), .game_over(game_over), .lives(lives),
        .score(score), .state(state));

    game_flow_controller #(.START_LIVES(LIVES0), .CRASH_FRAMES(CF),
        .SCORE_STEP_FRAMES(1), .BLINK_FRAMES(BF)) dut_sat (
        .clk(clk), .reset(reset_b), .start(start_b), .colision(colision_b),
        .frame_tick(frame_tick_b), .run_en(run_en_b), .clear_obs(clear_obs_b),
        .crash_blink(crash_blink_b), .game_over(game_over_b), .lives(lives_b),
        .score(score_b), .state(state_b));

    int checks = 0;
    int errors = 0;
    bit b_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- session model ----------------
    // Phases: 0 idle, 1 playing, 2 crashed, 3 game over.
    int m_phase = 0, m_lives = 0, m_score = 0;
    int run_ticks = 0, crash_ticks = 0;
    bit m_prev_start = 0, m_clear = 0;

    // Advance the model on each edge, then compare the DUT shortly after.
    always @(posedge clk) begin
        bit rise;
        if (reset) begin
            m_phase = 0; m_lives = 0; m_score = 0; m_clear = 0;
            m_prev_start = 0; run_ticks = 0; crash_ticks = 0;
        end else begin
            rise = start && !m_prev_start;
            m_clear = 0;
            case (m_phase)
                0: if (rise) begin
                    m_phase = 1; m_lives = LIVES0; m_score = 0;
                    m_clear = 1; run_ticks = 0;
                end
                1: if (colision) begin
                    m_phase = 2; crash_ticks = 0;
                    if (m_lives > 0) m_lives = m_lives - 1;
                end else if (frame_tick) begin
                    run_ticks++;
                    if (run_ticks % SSF == 0 && m_score < 65535) m_score++;
                end
                2: if (frame_tick) begin
                    crash_ticks++;
                    if (crash_ticks == CF) begin
                        if (m_lives == 0) m_phase = 3;
                        else begin m_phase = 1; m_clear = 1; run_ticks = 0; end
                    end
                end
                default: if (rise) m_phase = 0;
            endcase
            m_prev_start = start;
        end
        #1;
        chk("model_state", 32'(state), 32'(m_phase));
        chk("model_run_en", 32'(run_en), 32'(m_phase == 1));
        chk("model_game_over", 32'(game_over), 32'(m_phase == 3));
        chk("model_clear_obs", 32'(clear_obs), 32'(m_clear));
        chk("model_lives", 32'(lives), 32'(m_lives));
        chk("model_score", 32'(score), 32'(m_score));
        chk("model_blink", 32'(crash_blink),
            32'(m_phase == 2 && ((crash_ticks / BF) % 2 == 0)));
    end

    // One clock of stimulus: inputs change at the falling edge.
    task automatic cyc(input logic st, input logic ft, input logic co);
        start = st; frame_tick = ft; colision = co;
        @(negedge clk);
    endtask

    task automatic crash_run();
        cyc(0, 0, 1);
        repeat (4) cyc(0, 1, 0);
    endtask

    // Directed scenarios then randomized traffic on the main instance.
    initial begin
        logic [3:0] blink_exp;
        blink_exp = 4'b0011;   // index 0..3 -> 1,1,0,0
        reset = 1; start = 0; frame_tick = 0; colision = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        cyc(0, 0, 0);
        chk("reset_state", 32'(state), 0);
        chk("reset_lives", 32'(lives), 0);
        chk("reset_score", 32'(score), 0);
        chk("reset_run_en", 32'(run_en), 0);

        // New game
        cyc(1, 0, 0);
        chk("start_state", 32'(state), 1);
        chk("start_run_en", 32'(run_en), 1);
        chk("start_lives", 32'(lives), 3);
        chk("start_clear", 32'(clear_obs), 1);
        cyc(1, 0, 0);
        chk("start_clear_once", 32'(clear_obs), 0);

        // Six ticks with start held
        for (int i = 0; i < 6; i++) begin
            cyc(1, 1, 0);
            cyc(1, 0, 0);
        end
        chk("play_score3", 32'(score), 3);
        chk("play_hold_start", 32'(state), 1);

        // Collision coincident with a tick
        cyc(1, 1, 1);
        chk("crash_state", 32'(state), 2);
        chk("crash_lives", 32'(lives), 2);
        chk("crash_score", 32'(score), 3);
        chk("crash_run_en", 32'(run_en), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 1);
            chk("crash_blink_seq", 32'(crash_blink), 32'(blink_exp[i]));
            cyc(0, 1, 0);
        end
        chk("resume_state", 32'(state), 1);
        chk("resume_clear", 32'(clear_obs), 1);
        cyc(0, 0, 0);
        chk("resume_clear_once", 32'(clear_obs), 0);

        // Burn the remaining lives
        crash_run();
        chk("two_crash_lives", 32'(lives), 1);
        crash_run();
        chk("over_state", 32'(state), 3);
        chk("over_flag", 32'(game_over), 1);
        chk("over_lives", 32'(lives), 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("over_to_idle", 32'(state), 0);
        chk("idle_keeps_score", 32'(score), 3);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk("regame_state", 32'(state), 1);
        chk("regame_score", 32'(score), 0);
        chk("regame_lives", 32'(lives), 3);

        // Reset in the middle of a crash
        cyc(0, 0, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        reset = 1;
        cyc(0, 0, 0);
        chk("mid_crash_reset_state", 32'(state), 0);
        chk("mid_crash_reset_blink", 32'(crash_blink), 0);
        chk("mid_crash_reset_run", 32'(run_en), 0);
        chk("mid_crash_reset_clear", 32'(clear_obs), 0);

        // Reset beats a coincident start edge
        cyc(1, 0, 0);
        chk("reset_beats_start", 32'(state), 0);
        reset = 0;
        cyc(0, 0, 0);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(199) == 0);
            cyc(($urandom_range(7) == 0) ? ~start : start,
                $urandom_range(2) == 0,
                $urandom_range(11) == 0);
        end
        reset = 0;

        wait (b_done);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Score saturation on the one-tick-per-point instance.
    initial begin
        reset_b = 1; start_b = 0; colision_b = 0; frame_tick_b = 0;
        repeat (2) @(negedge clk);
        reset_b = 0;
        @(negedge clk);
        start_b = 1;
        @(negedge clk);
        chk("sat_start_state", 32'(state_b), 1);
        chk("sat_start_score", 32'(score_b), 0);
        frame_tick_b = 1;
        repeat (65534) @(negedge clk);
        chk("sat_preload", 32'(score_b), 32'hFFFE);
        repeat (4) @(negedge clk);
        chk("sat_max", 32'(score_b), 32'hFFFF);
        repeat (3) @(negedge clk);
        chk("sat_hold", 32'(score_b), 32'hFFFF);
        chk("sat_state", 32'(state_b), 1);
        frame_tick_b = 0;
        b_done = 1;
    end

    // Guard against a stalled run.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
